// File: rtl/xcalc_muldiv_pkg.sv
// Shared definitions for the xcalc multiply/divide responder: bus window,
// register offsets, op codes, STATUS bit positions and the engine state type.
package xcalc_muldiv_pkg;

    localparam logic [31:0] ALU_BASE   = 32'h0000_4000;
    localparam int          ALU_ADDR_W = 3;

    localparam logic [2:0] MD_OPA    = 3'd0;
    localparam logic [2:0] MD_OPB    = 3'd1;
    localparam logic [2:0] MD_CTRL   = 3'd2;
    localparam logic [2:0] MD_STATUS = 3'd3;
    localparam logic [2:0] MD_RLO    = 3'd4;
    localparam logic [2:0] MD_RHI    = 3'd5;

    localparam logic [1:0] MD_MUL = 2'd0;
    localparam logic [1:0] MD_DIV = 2'd1;
    localparam logic [1:0] MD_MOD = 2'd2;
    localparam logic [1:0] MD_RSV = 2'd3;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_DZ   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } md_state_t;

endpackage

// File: rtl/xcalc_muldiv_core.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide,
// one result bit per clock, with sign handling done around the unsigned core.
module xmuldiv_core
    import xcalc_muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done_pulse,
    output logic              dz,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    md_state_t           state, state_nxt;
    logic [1:0]          op_r;
    logic                sgn_r;
    logic                neg_p, neg_r;
    logic [DATA_W-1:0]   mb;
    logic [DATA_W:0]     r;
    logic [DATA_W-1:0]   q;
    logic [CNT_W-1:0]    cnt;

    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_rs;
    logic [DATA_W+1:0]   div_diff;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
    logic                div_zero;

    // Next-state logic; a zero divisor skips CALC and goes straight to FIX.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = div_zero ? FIX : CALC;
            CALC: if (cnt == CNT_W'(DATA_W - 1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand magnitudes, one iteration step and the sign-corrected results.
    always_comb begin
        div_zero = (op_r != MD_MUL) && (b == '0);
        a_neg    = sgn_r & a[DATA_W-1];
        b_neg    = sgn_r & b[DATA_W-1];
        mag_a    = a_neg ? (~a + 1'b1) : a;
        mag_b    = b_neg ? (~b + 1'b1) : b;
        mul_sum  = r + (q[0] ? {1'b0, mb} : '0);
        div_rs   = {r[DATA_W-1:0], q[DATA_W-1]};
        div_diff = {1'b0, div_rs} - {2'b00, mb};
        prod     = {r[DATA_W-1:0], q};
        prod_fix = neg_p ? (~prod + 1'b1) : prod;
        quo_fix  = neg_p ? (~q + 1'b1) : q;
        rem_fix  = neg_r ? (~r[DATA_W-1:0] + 1'b1) : r[DATA_W-1:0];
    end

    assign busy       = (state != IDLE);
    assign done_pulse = (state == FIX);

    // State register plus datapath registers, all cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_r  <= MD_MUL;
            sgn_r <= 1'b0;
            neg_p <= 1'b0;
            neg_r <= 1'b0;
            mb    <= '0;
            r     <= '0;
            q     <= '0;
            cnt   <= '0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        sgn_r <= is_signed;
                        dz    <= 1'b0;
                    end
                end
                LOAD: begin
                    q     <= mag_a;
                    mb    <= mag_b;
                    r     <= '0;
                    cnt   <= '0;
                    neg_p <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    if (div_zero) dz <= 1'b1;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_r == MD_MUL) begin
                        r <= {1'b0, mul_sum[DATA_W:1]};
                        q <= {mul_sum[0], q[DATA_W-1:1]};
                    end else if (!div_diff[DATA_W+1]) begin
                        r <= div_diff[DATA_W:0];
                        q <= {q[DATA_W-2:0], 1'b1};
                    end else begin
                        r <= div_rs;
                        q <= {q[DATA_W-2:0], 1'b0};
                    end
                end
                FIX: begin
                    if (dz) begin
                        lo <= '1;
                        hi <= a;
                    end else if (op_r == MD_MUL) begin
                        {hi, lo} <= prod_fix;
                    end else if (op_r == MD_DIV) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        lo <= rem_fix;
                        hi <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/xcalc_muldiv.sv
// Memory-mapped front end for the multiply/divide engine: operand and control
// registers, done flag, read mux and interrupt.
module xcalc_muldiv
    import xcalc_muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_to_rd,
    output logic              irq
);

    logic [DATA_W-1:0] opa, opb;
    logic [2:0]        ctrl;
    logic              done;
    logic              core_busy, core_done, core_dz;
    logic [DATA_W-1:0] core_hi, core_lo;
    logic              wr_ok, start;

    assign wr_ok = sel && we && !core_busy;
    assign start = wr_ok && (addr == MD_CTRL) && (data_in[1:0] != MD_RSV);
    assign irq   = done;

    xmuldiv_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (data_in[1:0]),
        .is_signed  (data_in[2]),
        .a          (opa),
        .b          (opb),
        .busy       (core_busy),
        .done_pulse (core_done),
        .dz         (core_dz),
        .hi         (core_hi),
        .lo         (core_lo)
    );

    // Host-writable registers and the sticky done flag; writes are dropped while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opa  <= '0;
            opb  <= '0;
            ctrl <= '0;
            done <= 1'b0;
        end else begin
            if (wr_ok) begin
                case (addr)
                    MD_OPA:  opa  <= data_in;
                    MD_OPB:  opb  <= data_in;
                    MD_CTRL: ctrl <= data_in[2:0];
                    default: ;
                endcase
            end
            if (start)          done <= 1'b0;
            else if (core_done) done <= 1'b1;
        end
    end

    // Combinational read mux; returns zero unless this is a selected read.
    always_comb begin
        data_to_rd = '0;
        if (sel && !we) begin
            case (addr)
                MD_OPA:    data_to_rd = opa;
                MD_OPB:    data_to_rd = opb;
                MD_CTRL:   data_to_rd = DATA_W'(ctrl);
                MD_STATUS: data_to_rd = DATA_W'({core_dz, done, core_busy});
                MD_RLO:    data_to_rd = core_lo;
                MD_RHI:    data_to_rd = core_hi;
                default:   data_to_rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_xcalc_muldiv.sv
// Directed testbench for xcalc_muldiv with hand-computed expected values.
module tb_xcalc_muldiv;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_to_rd;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;

    xcalc_muldiv dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .we         (we),
        .addr       (addr),
        .data_in    (data_in),
        .data_to_rd (data_to_rd),
        .irq        (irq)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus write; the sampling rising edge is the only edge consumed.
    task automatic apply_stimulus(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; data_in = '0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        d = data_to_rd;
        sel = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        read_reg(a, d);
        check_output(tag, d, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++)
            check_reg($sformatf("reset_reg%0d", i), 3'(i), 32'h0);
        check_output("reset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Unsigned MUL 0xFFFFFFFF * 0xFFFFFFFF
        apply_stimulus(3'd0, 32'hFFFF_FFFF);
        apply_stimulus(3'd1, 32'hFFFF_FFFF);
        apply_stimulus(3'd2, 32'h0);
        check_reg("mul_busy_start", 3'd3, 32'h1);
        wait_cycles(33);
        check_reg("mul_busy_k33", 3'd3, 32'h1);
        check_output("mul_irq_k33", {31'b0, irq}, 32'h0);
        wait_cycles(1);
        check_reg("mul_status_done", 3'd3, 32'h2);
        check_output("mul_irq_done", {31'b0, irq}, 32'h1);
        check_reg("mul_lo", 3'd4, 32'h0000_0001);
        check_reg("mul_hi", 3'd5, 32'hFFFF_FFFE);

        // Signed DIV -7 / 2
        apply_stimulus(3'd0, 32'hFFFF_FFF9);
        apply_stimulus(3'd1, 32'h2);
        apply_stimulus(3'd2, 32'h5);
        check_reg("sdiv_done_cleared", 3'd3, 32'h1);
        wait_cycles(34);
        check_reg("sdiv_status", 3'd3, 32'h2);
        check_reg("sdiv_lo", 3'd4, 32'hFFFF_FFFD);
        check_reg("sdiv_hi", 3'd5, 32'hFFFF_FFFF);
        check_reg("sdiv_ctrl", 3'd2, 32'h5);

        // Divide by zero
        apply_stimulus(3'd0, 32'h1234);
        apply_stimulus(3'd1, 32'h0);
        apply_stimulus(3'd2, 32'h1);
        wait_cycles(1);
        check_output("dz_no_done_k1", {31'b0, irq}, 32'h0);
        wait_cycles(1);
        check_reg("dz_status", 3'd3, 32'h6);
        check_reg("dz_lo", 3'd4, 32'hFFFF_FFFF);
        check_reg("dz_hi", 3'd5, 32'h1234);

        // Writes while busy are ignored
        apply_stimulus(3'd0, 32'd3);
        apply_stimulus(3'd1, 32'd5);
        apply_stimulus(3'd2, 32'h0);
        wait_cycles(8);
        apply_stimulus(3'd0, 32'd9);
        apply_stimulus(3'd2, 32'h1);
        wait_cycles(24);
        check_reg("wbusy_status", 3'd3, 32'h2);
        check_reg("wbusy_lo", 3'd4, 32'd15);
        check_reg("wbusy_hi", 3'd5, 32'd0);
        check_reg("wbusy_ctrl", 3'd2, 32'h0);
        check_reg("wbusy_opa", 3'd0, 32'd3);

        // Reset in the middle of a divide, then a MOD
        apply_stimulus(3'd0, 32'd100);
        apply_stimulus(3'd1, 32'd7);
        apply_stimulus(3'd2, 32'h1);
        wait_cycles(15);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 6; i++)
            check_reg($sformatf("midrst_reg%0d", i), 3'(i), 32'h0);
        check_output("midrst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(3'd0, 32'd17);
        apply_stimulus(3'd1, 32'd5);
        apply_stimulus(3'd2, 32'h2);
        wait_cycles(34);
        check_reg("mod_status", 3'd3, 32'h2);
        check_reg("mod_lo", 3'd4, 32'd2);
        check_reg("mod_hi", 3'd5, 32'd3);

        // Address decode and reserved op
        sel = 1'b0; we = 1'b0; addr = 3'd4;
        #1;
        check_output("decode_sel0", data_to_rd, 32'h0);
        check_reg("decode_addr6", 3'd6, 32'h0);
        check_reg("decode_addr7", 3'd7, 32'h0);
        sel = 1'b1; we = 1'b1; addr = 3'd4; data_in = 32'h0;
        #1;
        check_output("decode_we1", data_to_rd, 32'h0);
        sel = 1'b0; we = 1'b0;
        apply_stimulus(3'd2, 32'h3);
        check_reg("rsv_status", 3'd3, 32'h2);
        wait_cycles(2);
        check_reg("rsv_status_later", 3'd3, 32'h2);
        check_reg("rsv_ctrl", 3'd2, 32'h3);
        check_reg("rsv_lo_kept", 3'd4, 32'd2);

        // Signed -2^31 / -1
        apply_stimulus(3'd0, 32'h8000_0000);
        apply_stimulus(3'd1, 32'hFFFF_FFFF);
        apply_stimulus(3'd2, 32'h5);
        wait_cycles(34);
        check_reg("minneg_status", 3'd3, 32'h2);
        check_reg("minneg_lo", 3'd4, 32'h8000_0000);
        check_reg("minneg_hi", 3'd5, 32'h0);

        // Signed MUL -3 * 5
        apply_stimulus(3'd0, 32'hFFFF_FFFD);
        apply_stimulus(3'd1, 32'd5);
        apply_stimulus(3'd2, 32'h4);
        wait_cycles(34);
        check_reg("smul_lo", 3'd4, 32'hFFFF_FFF1);
        check_reg("smul_hi", 3'd5, 32'hFFFF_FFFF);

        // Signed MOD 7 mod -2
        apply_stimulus(3'd0, 32'd7);
        apply_stimulus(3'd1, 32'hFFFF_FFFE);
        apply_stimulus(3'd2, 32'h6);
        wait_cycles(34);
        check_reg("smod_lo", 3'd4, 32'd1);
        check_reg("smod_hi", 3'd5, 32'hFFFF_FFFD);

        // Unsigned DIV of a large dividend
        apply_stimulus(3'd0, 32'hFFFF_FFF9);
        apply_stimulus(3'd1, 32'd2);
        apply_stimulus(3'd2, 32'h1);
        wait_cycles(34);
        check_reg("udiv_lo", 3'd4, 32'h7FFF_FFFC);
        check_reg("udiv_hi", 3'd5, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/xcalc_muldiv.md
Name: xcalc_muldiv

Overview:
- Memory-mapped iterative multiply/divide responder for the calculator SoC.
- Sits behind the address decoder on the processor data bus and is enabled by its decoded select (`alu_sel`).
- Software writes the operands and a command, polls STATUS, then reads RESULT_LO and RESULT_HI.
- Replaces a single-cycle ALU path with a small sequential engine: one result bit per clock.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  reset; asynchronous, active-low. Asserting it clears all state immediately.
- sel  in  1  decoded select from the address decoder.
- we  in  1  write enable; qualifies sel.
- addr  in  3  word offset inside the block window.
- data_in  in  DATA_W  write data.
- data_to_rd  out  DATA_W  read data; combinational.
- irq  out  1  level, equal to the done bit.

Behaviour:
- Register map (addr):
  - 0 OPA, RW.
  - 1 OPB, RW.
  - 2 CTRL, W: bits[1:0] op (0 MUL, 1 DIV, 2 MOD, 3 reserved); bit2 signed. Reads as {29'b0, last CTRL}.
  - 3 STATUS, R: bit0 busy, bit1 done, bit2 div_by_zero.
  - 4 RESULT_LO, R.
  - 5 RESULT_HI, R.
  - 6 and 7 read 0; writes ignored.
- Reset values: OPA, OPB, CTRL, RESULT_LO, RESULT_HI = 0; busy = done = div_by_zero = 0; irq = 0; FSM in IDLE.
- data_to_rd = 0 when sel = 0 or we = 1; otherwise the addressed register. Reads have no side effects.
- Start condition: write to CTRL while IDLE with op != 3.
- Side effects at the start edge: done and div_by_zero clear, busy sets.
- CTRL write with op = 3: CTRL updates, no start, done unchanged.
- Writes to OPA, OPB or CTRL while busy are ignored. The host must poll STATUS.
- FSM states: IDLE, LOAD, CALC, FIX.
  - IDLE to LOAD on start.
  - LOAD (1 cycle): latch operand magnitudes (two's-complement absolute value if signed = 1) and result signs; clear accumulator; counter = 0.
    - DIV/MOD with OPB == 0: set div_by_zero, RESULT_LO = all ones, RESULT_HI = OPA (raw), go to IDLE with done = 1.
  - CALC (DATA_W cycles, counter 0..DATA_W-1):
    - MUL: shift-add, one multiplier bit per cycle.
    - DIV/MOD: restoring division, one quotient bit per cycle; remainder kept DATA_W+1 bits.
  - FIX (1 cycle): apply sign correction and write the result registers.
    - MUL: 2*DATA_W-bit product to {RESULT_HI, RESULT_LO}.
    - DIV: RESULT_LO = quotient, RESULT_HI = remainder.
    - MOD: RESULT_LO = remainder, RESULT_HI = quotient.
    - Then busy clears, done sets, go to IDLE.
- Latency: a start at edge k gives done = 1 from edge k+DATA_W+2 (34 for DATA_W = 32). Divide-by-zero gives done from edge k+2.
- Sign rules:
  - Product sign = signA xor signB.
  - Quotient sign = signA xor signB; remainder sign = signA (truncating division).
  - Signed -2^31 / -1 yields quotient 0x80000000, remainder 0, div_by_zero = 0.
  - Unsigned mode treats all operands as unsigned.
- done stays set until the next start or reset.
- Reset mid-operation aborts immediately; all registers return to reset values.

Decomposition:
- Shared defines header (xdefs.vh):
  - ALU_BASE and ALU_ADDR_W.
  - Register offsets: MD_OPA, MD_OPB, MD_CTRL, MD_STATUS, MD_RLO, MD_RHI.
  - Op codes: MD_MUL, MD_DIV, MD_MOD.
  - STATUS bit indices.
- One sub-module: xmuldiv_core.
  - Contains the FSM, datapath and counter.
  - Interface: start, op, signed, a, b in; busy, done_pulse, dz, hi, lo out.
- The top level handles the register file and read mux.

Test Plan:
- Unsigned MUL: OPA = 0xFFFFFFFF, OPB = 0xFFFFFFFF, CTRL = 0x0 -> busy for 33 cycles; done at cycle 34; RESULT_HI = 0xFFFFFFFE, RESULT_LO = 0x00000001.
- Signed DIV: OPA = 0xFFFFFFF9 (-7), OPB = 2, CTRL = 0x5 -> RESULT_LO = 0xFFFFFFFD (-3), RESULT_HI = 0xFFFFFFFF (-1), STATUS = 0x2.
- Divide by zero: OPA = 0x1234, OPB = 0, CTRL = 0x1 -> STATUS = 0x6 two cycles after the write; RESULT_LO = 0xFFFFFFFF, RESULT_HI = 0x1234.
- Write while busy: start MUL 3*5, write OPA = 9 and CTRL = 0x1 at cycle 10 -> ignored; result 15 / 0; CTRL readback still 0x0.
- Reset mid-CALC: drop rst at cycle 15 of a DIV -> all reads return 0, irq = 0; a new MOD 17 mod 5 afterwards gives RESULT_LO = 2, RESULT_HI = 3.
- Address decode: sel = 0 or addr = 6 -> data_to_rd = 0. CTRL write with op = 3 -> no busy, done unchanged.
